audio_serializer: RTL and testbench



---
 rtl/audio_serializer_pkg.sv | 8 +
 rtl/audio_serializer_bit_period_counter.sv | 31 +++
 rtl/audio_serializer.sv | 103 ++++++++++
 tb/tb_audio_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_serializer_pkg.sv
// Shared types and defaults for the audio serializer.
package serializer_pkg;

    typedef enum logic {IDLE, SHIFT} ser_state_t;

    localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/audio_serializer_bit_period_counter.sv
// Counts clocks within one serial bit; tick marks the last clock of the bit.
module bit_period_counter #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    // Keep at least one bit of counter so CLKS_PER_BIT=1 still elaborates.
    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLKS_PER_BIT - 1);

    logic [PW-1:0] count;

    assign tick = run && (count == LAST);

    // Period counter: cleared while idle/loading, wraps at the end of each bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (run) begin
            count <= count + PW'(1);
        end
    end

endmodule

// File: rtl/audio_serializer.sv
// Parallel-to-serial converter for the 1-bit audio output path.
// Default build shifts MSB-first; define SERIALIZER_LSB_FIRST_EN for LSB-first.
module audio_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int CLKS_PER_BIT = 1,
    parameter int CNT_W        = $clog2(DATA_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    output logic              done,
    output logic              audio_data,
    output logic              audio_enable,
    output logic [CNT_W-1:0]  countero
);

`ifdef SERIALIZER_LSB_FIRST_EN
    localparam int FIRST_IDX = 0;
    localparam int NEXT_IDX  = 1;
`else
    localparam int FIRST_IDX = DATA_W - 1;
    localparam int NEXT_IDX  = DATA_W - 2;
`endif

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    ser_state_t        state;
    logic [DATA_W-1:0] shreg;
    logic              tick;

    // Move the word one place so the next bit to send sits at NEXT_IDX.
    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
`ifdef SERIALIZER_LSB_FIRST_EN
        return w >> 1;
`else
        return w << 1;
`endif
    endfunction

    bit_period_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_period (
        .clock (clock),
        .reset (reset),
        .clear (state == IDLE),
        .run   (state == SHIFT),
        .tick  (tick)
    );

    // Serializer FSM: load, shift on bit ticks, reload or stop at word end, abort on enable low.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            audio_data   <= 1'b0;
            audio_enable <= 1'b0;
            done         <= 1'b0;
            countero     <= '0;
        end else begin
            audio_enable <= enable;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    countero <= '0;
                    if (enable) begin
                        shreg      <= data_in;
                        audio_data <= data_in[FIRST_IDX];
                        state      <= SHIFT;
                    end else begin
                        audio_data <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Word end takes priority so a stop on the last bit still reports done.
                    if (tick && countero == LAST_BIT) begin
                        done     <= 1'b1;
                        countero <= '0;
                        if (enable) begin
                            shreg      <= data_in;
                            audio_data <= data_in[FIRST_IDX];
                        end else begin
                            state      <= IDLE;
                            audio_data <= 1'b0;
                        end
                    end else if (!enable) begin
                        state      <= IDLE;
                        audio_data <= 1'b0;
                        countero   <= '0;
                    end else if (tick) begin
                        countero   <= countero + CNT_W'(1);
                        shreg      <= shift_word(shreg);
                        audio_data <= shreg[NEXT_IDX];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_serializer.sv
// Directed bench for audio_serializer: one instance at 1 clk/bit, one at 4 clks/bit.
module tb_audio_serializer;

    logic        clock;
    logic        reset;
    logic        enable, enable4;
    logic [15:0] data_in, data_in4;
    logic        done, done4;
    logic        audio_data, audio_data4;
    logic        audio_enable, audio_enable4;
    logic [3:0]  countero, countero4;

    int checks = 0;
    int errors = 0;

    audio_serializer #(.DATA_W(16), .CLKS_PER_BIT(1), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
        .done(done), .audio_data(audio_data), .audio_enable(audio_enable),
        .countero(countero)
    );

    audio_serializer #(.DATA_W(16), .CLKS_PER_BIT(4), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .enable(enable4), .data_in(data_in4),
        .done(done4), .audio_data(audio_data4), .audio_enable(audio_enable4),
        .countero(countero4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reset held with enable high: every output stays zero.
    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; enable4 = 1'b1;
        data_in = 16'hFFFF; data_in4 = 16'hFFFF;
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({audio_data, done, countero, audio_enable} !== 7'd0) begin
                errors++;
                $display("FAIL reset cyc%0d: data=%b done=%b cnt=%0d aen=%b, want all 0",
                         i, audio_data, done, countero, audio_enable);
            end
            checks++;
            if ({audio_data4, done4, countero4, audio_enable4} !== 7'd0) begin
                errors++;
                $display("FAIL reset4 cyc%0d: data=%b done=%b cnt=%0d aen=%b, want all 0",
                         i, audio_data4, done4, countero4, audio_enable4);
            end
        end
        enable = 1'b0; enable4 = 1'b0; reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({audio_data, done, countero, audio_enable} !== 7'd0) begin
            errors++;
            $display("FAIL idle: data=%b done=%b cnt=%0d aen=%b, want all 0",
                     audio_data, done, countero, audio_enable);
        end
    endtask

    // Word A5AF MSB-first; data_in switched to 8001 mid-word must not disturb it.
    task automatic test_single_word();
        logic [15:0] w;
        w = 16'hA5AF;
        data_in = w; enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            checks++;
            if (audio_data !== w[15-i] || countero !== 4'(i) || done !== 1'b0 ||
                audio_enable !== 1'b1) begin
                errors++;
                $display("FAIL word1 bit%0d: data=%b cnt=%0d done=%b aen=%b, want data=%b cnt=%0d done=0 aen=1",
                         i, audio_data, countero, done, audio_enable, w[15-i], i);
            end
            if (i == 5) data_in = 16'h8001;
        end
    endtask

    // Second word follows with no gap; done marks the boundary; stop at word end.
    task automatic test_back_to_back();
        logic [15:0] w;
        w = 16'h8001;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            checks++;
            if (audio_data !== w[15-i] || countero !== 4'(i) || done !== (i == 0)) begin
                errors++;
                $display("FAIL word2 bit%0d: data=%b cnt=%0d done=%b, want data=%b cnt=%0d done=%b",
                         i, audio_data, countero, done, w[15-i], i, (i == 0));
            end
            if (i == 15) enable = 1'b0;
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || audio_data !== 1'b0 || countero !== 4'd0 || audio_enable !== 1'b0) begin
            errors++;
            $display("FAIL word2 end: done=%b data=%b cnt=%0d aen=%b, want done=1 data=0 cnt=0 aen=0",
                     done, audio_data, countero, audio_enable);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || audio_data !== 1'b0) begin
            errors++;
            $display("FAIL after stop: done=%b data=%b, want 0 0", done, audio_data);
        end
    endtask

    // Four clocks per bit: FFFF held 64 cycles, counter steps every 4, one done.
    task automatic test_slow_bits();
        int ndone;
        ndone = 0;
        data_in4 = 16'hFFFF; enable4 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            checks++;
            if (audio_data4 !== 1'b1 || countero4 !== 4'(i / 4) || done4 !== 1'b0) begin
                errors++;
                $display("FAIL slow cyc%0d: data=%b cnt=%0d done=%b, want data=1 cnt=%0d done=0",
                         i, audio_data4, countero4, done4, i / 4);
            end
            if (i == 63) enable4 = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done4 === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 1 || audio_data4 !== 1'b0) begin
            errors++;
            $display("FAIL slow end: done pulses=%0d data=%b, want 1 pulse data=0", ndone, audio_data4);
        end
    endtask

    // Enable dropped at bit 7: abort to idle with no done pulse.
    task automatic test_abort();
        data_in = 16'hFFFF; enable = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clock);
        checks++;
        if (countero !== 4'd7 || audio_data !== 1'b1 || audio_enable !== 1'b1) begin
            errors++;
            $display("FAIL abort pre: cnt=%0d data=%b aen=%b, want 7 1 1", countero, audio_data, audio_enable);
        end
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if (audio_data !== 1'b0 || countero !== 4'd0 || done !== 1'b0 || audio_enable !== 1'b0) begin
            errors++;
            $display("FAIL abort: data=%b cnt=%0d done=%b aen=%b, want 0 0 0 0",
                     audio_data, countero, done, audio_enable);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || audio_data !== 1'b0 || countero !== 4'd0) begin
                errors++;
                $display("FAIL abort idle cyc%0d: done=%b data=%b cnt=%0d, want 0 0 0",
                         i, done, audio_data, countero);
            end
        end
    endtask

    // Word 0001: LSB-first build sends 1 then zeros; default build sends zeros then 1.
    task automatic test_bit_order();
        logic [15:0] w;
        logic        exp;
        w = 16'h0001;
        data_in = w; enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
`ifdef SERIALIZER_LSB_FIRST_EN
            exp = w[i];
`else
            exp = w[15-i];
`endif
            checks++;
            if (audio_data !== exp || countero !== 4'(i) || done !== 1'b0) begin
                errors++;
                $display("FAIL order bit%0d: data=%b cnt=%0d done=%b, want data=%b cnt=%0d done=0",
                         i, audio_data, countero, done, exp, i);
            end
            if (i == 15) enable = 1'b0;
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || audio_data !== 1'b0) begin
            errors++;
            $display("FAIL order end: done=%b data=%b, want 1 0", done, audio_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_slow_bits();
        test_abort();
        test_bit_order();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
